// File: rtl/radar_serial_tx.sv
// Buffers NUM_CH-word entries in a FIFO and shifts them out MSB-first with word/frame markers and gaps.
// Strobe-to-first-bit latency is 3 clk; no backpressure, so an entry arriving at a full FIFO is dropped and flagged.
module radar_serial_tx #(
  parameter int DATA_W     = 12,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int BIT_DIV    = 16,
  parameter int GAP_BITS   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     in_frame,
  input  logic                     ovf_clr,
  output logic                     ser_data,
  output logic                     ser_word,
  output logic                     ser_frame,
  output logic                     fifo_full,
  output logic                     overflow,
  output logic                     busy
);
  localparam int TOT_W   = NUM_CH * DATA_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int GAP_CYC = GAP_BITS * BIT_DIV;
  localparam int TMR_MAX = (GAP_CYC > BIT_DIV) ? GAP_CYC : BIT_DIV;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IDX_W   = $clog2(TOT_W + 1);
  localparam int WPOS_W  = $clog2(DATA_W + 1);

  localparam logic [PTR_W:0]    DEPTH_C      = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0]  TMR_BIT_LAST = TMR_W'(BIT_DIV - 1);
  localparam logic [TMR_W-1:0]  TMR_GAP_LAST = TMR_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(TOT_W - 1);
  localparam logic [WPOS_W-1:0] WPOS_LAST    = WPOS_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef struct packed {
    logic             frame;
    logic [TOT_W-1:0] bits;
  } entry_t;

  logic rst_meta_q, rst_sync_q;
  entry_t mem_q [FIFO_DEPTH];
  entry_t wr_ent;
  logic   pop, push, drop;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [WPOS_W-1:0] wpos_q, wpos_d;
  logic [TOT_W-1:0]  shreg_q, shreg_d;
  logic tag_q, tag_d, ovf_q, ovf_d;
  logic ser_data_q, ser_data_d, ser_word_q, ser_word_d, ser_frame_q, ser_frame_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Entries are stored channel-reordered so the shifter only ever looks at its MSB.
  always_comb begin
    wr_ent.frame = in_frame;
    wr_ent.bits  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      wr_ent.bits[TOT_W-1-k*DATA_W -: DATA_W] = in_data[k*DATA_W +: DATA_W];
    end
    pop      = (state_q == ST_IDLE) && (count_q != '0);
    push     = in_valid && ((count_q != DEPTH_C) || pop);
    drop     = in_valid && !push;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    ovf_d    = drop | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_ent;
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_idx_d = bit_idx_q;
    wpos_d    = wpos_q;
    shreg_d   = shreg_q;
    tag_d     = tag_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          shreg_d = mem_q[rd_ptr_q].bits;
          tag_d   = mem_q[rd_ptr_q].frame;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tmr_d     = '0;
        bit_idx_d = '0;
        wpos_d    = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tmr_q == TMR_BIT_LAST) begin
          tmr_d     = '0;
          shreg_d   = shreg_q << 1;
          bit_idx_d = bit_idx_q + IDX_W'(1);
          wpos_d    = (wpos_q == WPOS_LAST) ? '0 : wpos_q + WPOS_W'(1);
          if (bit_idx_q == IDX_LAST) state_d = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        if (tmr_q == TMR_GAP_LAST) begin
          tmr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
    endcase
    ser_data_d  = (state_q == ST_SHIFT) && shreg_q[TOT_W-1];
    ser_word_d  = (state_q == ST_SHIFT) && (wpos_q == '0);
    ser_frame_d = (state_q == ST_SHIFT) && tag_q && (bit_idx_q == '0);
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      bit_idx_q   <= '0;
      wpos_q      <= '0;
      shreg_q     <= '0;
      tag_q       <= 1'b0;
      ovf_q       <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_word_q  <= 1'b0;
      ser_frame_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bit_idx_q   <= bit_idx_d;
      wpos_q      <= wpos_d;
      shreg_q     <= shreg_d;
      tag_q       <= tag_d;
      ovf_q       <= ovf_d;
      ser_data_q  <= ser_data_d;
      ser_word_q  <= ser_word_d;
      ser_frame_q <= ser_frame_d;
    end
  end

  assign ser_data  = ser_data_q;
  assign ser_word  = ser_word_q;
  assign ser_frame = ser_frame_q;
  assign fifo_full = (count_q == DEPTH_C);
  assign overflow  = ovf_q;
  assign busy      = (state_q != ST_IDLE) || (count_q != '0);
endmodule

// File: doc/radar_serial_tx.md
Name: radar_serial_tx

Overview:
- Parametrised successor to the radar serial output stage.
- Accepts NUM_CH magnitude words per FFT output strobe and buffers them in an internal FIFO.
- Shifts each buffered entry out MSB-first on a single data line. Bit timing comes from an internal clock-enable counter, not a divided clock.
- Adds per-word and per-frame markers, inter-entry gap bits, a configurable channel count, and overflow detection with a sticky flag.

Parameters:
DATA_W, 12, width of one magnitude word.
NUM_CH, 2, words per input entry; channel 0 is transmitted first.
FIFO_DEPTH, 16, entries buffered; power of two, >=2.
BIT_DIV, 16, clk cycles per serial bit; >=2.
GAP_BITS, 2, idle bit periods inserted after each entry; 0 is allowed.

Ports:
clk  in  1  system clock; one clock domain only.
reset_n  in  1  asynchronous active-low reset.
in_valid  in  1  one-cycle strobe: in_data and in_frame are valid.
in_data  in  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
in_frame  in  1  entry is the first bin of an FFT frame.
ovf_clr  in  1  synchronous clear of overflow.
ser_data  out  1  serial data, MSB of each word first.
ser_word  out  1  high for the first bit period of every word (next_data equivalent).
ser_frame  out  1  high for the first bit period of an entry tagged in_frame.
fifo_full  out  1  count == FIFO_DEPTH.
overflow  out  1  sticky: an entry was dropped.
busy  out  1  state != IDLE or FIFO not empty.

Behaviour:
- Reset (async assert, sync deassert internally):
  - All outputs 0.
  - FIFO count 0, pointers 0.
  - Bit counter 0, state IDLE.
  - Any entry in flight is discarded, with no partial completion.
- FIFO write:
  - in_valid writes the entry plus its in_frame tag when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow is set the next cycle.
  - Writes and pops in the same cycle leave count unchanged.
- Overflow flag:
  - overflow holds until ovf_clr or reset.
  - ovf_clr and a drop in the same cycle: overflow remains 1.
- FSM states: IDLE, LOAD, SHIFT, GAP.
- IDLE: when the FIFO is non-empty, pop the head into the shift register; go to LOAD.
- LOAD (1 cycle): set bit index to 0 and bit counter to 0; latch the frame tag; go to SHIFT.
- SHIFT:
  - ser_data = current bit, channel 0 MSB first, then channel 1, and so on; NUM_CH*DATA_W bits total.
  - Each bit is held exactly BIT_DIV cycles. The counter counts 0..BIT_DIV-1; the bit advances on wrap.
  - ser_word = 1 during bit indices that are multiples of DATA_W.
  - ser_frame = 1 during bit index 0 if the tag is set.
  - After the last bit: go to GAP if GAP_BITS > 0, otherwise go to IDLE.
- GAP:
  - ser_data, ser_word and ser_frame = 0 for GAP_BITS*BIT_DIV cycles.
  - Then IDLE; a pending entry is popped that same cycle.
- Serial outputs are registered.
  - in_valid sampled at edge E0 with the FIFO empty and state IDLE: pop at E1, LOAD at E2, first bit visible after E3.
  - Latency is 3 clk from strobe to first bit.
- Idle line: ser_data = 0 outside SHIFT.
- Entry period is (NUM_CH*DATA_W + GAP_BITS)*BIT_DIV + 2 clk. Back-to-back entries are separated only by the GAP and the IDLE/LOAD cycles.
- fifo_full reflects the registered count; it does not look ahead at a same-cycle pop.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

Test Plan:
- Reset, then one entry (DATA_W=12, NUM_CH=2, BIT_DIV=4, GAP_BITS=2), in_data={12'h001, 12'hA5C}, in_frame=1:
  - First bit 3 clk after the strobe.
  - Bit sequence 1010_0101_1100 then 0000_0000_0001.
  - ser_word high for bits 0 and 12.
  - ser_frame high for bit 0 only.
  - 8 idle clk follow, then busy=0.
- Burst of 18 strobes on consecutive cycles (FIFO_DEPTH=16):
  - The first entry is popped before the FIFO fills, so 17 are accepted and 1 is dropped.
  - overflow=1, fifo_full=1.
  - 17 entries are serialised in order.
- Drop with ovf_clr in the same cycle: overflow stays 1. ovf_clr alone the next cycle: overflow goes to 0.
- FIFO full with a pop in the same cycle as in_valid: the entry is accepted, count stays 16, overflow stays 0.
- Assert reset_n low mid-SHIFT (bit 7 of entry 2):
  - All outputs go to 0 immediately.
  - After release, busy=0 and no residual bits appear.
- Parameter sweep (NUM_CH=4, DATA_W=8, BIT_DIV=2, GAP_BITS=0):
  - Entries are separated only by the IDLE+LOAD cycles, i.e. 2 clk with ser_data=0 between entries.
  - ser_word pulses 4 times per entry.
